branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Tracks each conditional branch from decode to the memory stage alongside the 2-bit branch predictor, compares the predicted direction with the resolved outcome, and drives the fetch-stage recovery. On a mismatch it asserts a one-cycle mispredict, supplies the corrected PC, and squashes the younger in-flight branch record. It also maintains saturating branch and misprediction counters for performance measurement.

## Interface
Parameters:
- CNT_WIDTH, 32, width of both performance counters.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  pipeline hold; freezes all records and counters.
- branch_decode_sig  in  1  a conditional branch is in decode this cycle.
- prediction  in  1  predictor direction for the decode branch (1 = taken).
- decode_pc  in  32  PC of the decode branch.
- branch_addr  in  32  taken target for the decode branch (decode_pc + offset).
- branch_mem_sig  in  1  a branch is resolving in the memory stage.
- actual_branch_decision  in  1  resolved direction (1 = taken).
- mispredict  out  1  predicted and resolved directions differ.
- recover_pc  out  32  PC fetch must redirect to when mispredict = 1.
- branch_count  out  CNT_WIDTH  branches resolved since reset.
- mispredict_count  out  CNT_WIDTH  mispredictions since reset.
- orphan_err  out  1  sticky flag: resolution arrived with no tracked record.

## Operation
- Record = {valid, pred, fallthrough, target}; fallthrough = decode_pc + 32'd4 (mod 2^32, wraps silently); target = branch_addr.
- Two record registers, ex_rec and mem_rec, form a shift pipeline: decode -> ex_rec -> mem_rec.
- Advance (posedge, stall = 0, no mispredict): mem_rec <= ex_rec; ex_rec <= {branch_decode_sig, prediction, fallthrough, target}.
- Resolution is active when branch_mem_sig = 1 and mem_rec.valid = 1.
  - mispredict = mem_rec.pred XOR actual_branch_decision (combinational, gated by active resolution and stall = 0).
  - recover_pc = actual_branch_decision ? mem_rec.target : mem_rec.fallthrough; it is 32'h0 when mispredict = 0.
- On the posedge with mispredict = 1: ex_rec.valid <= 0 (squash the younger branch), mem_rec.valid <= 0, and the decode branch is not captured (ex_rec cleared).
- On the posedge of an active resolution without mispredict: mem_rec is consumed (next value from ex_rec as normal).
- Counters: branch_count increments on every active resolution (stall = 0); mispredict_count increments when mispredict = 1. Both saturate at all-ones and never wrap.
- If branch_mem_sig = 1 and mem_rec.valid = 0 with stall = 0: orphan_err <= 1 (sticky until reset), mispredict = 0, no counter change.
- If mem_rec.valid = 1 but branch_mem_sig = 0: the record is discarded on advance, not counted, and no error is raised (the branch was killed upstream).

## Timing
- Reset values: ex_rec.valid = 0, mem_rec.valid = 0, mispredict = 0, recover_pc = 32'h0, branch_count = 0, mispredict_count = 0, orphan_err = 0. Reset overrides stall and any in-flight resolution.
- Decode-to-resolve latency: a branch captured at edge N sits in mem_rec after edge N+1 and resolves in the cycle that follows.
- mispredict and recover_pc are valid in the same cycle as branch_mem_sig, with zero-cycle latency, so fetch redirects at the next posedge.
- Counters and orphan_err update one edge after the resolving cycle.
- stall = 1: all registers hold, mispredict is forced to 0, and counters hold; the resolution retries when stall drops.
- Simultaneous decode branch and mispredict in the same cycle: the mispredict wins and the decode branch is dropped.
- Back-to-back branches need no special handling; each record resolves independently.

## Test plan
- Reset, then decode at PC 0x100 with prediction = 1, target 0x140, actual = 1 two cycles later -> mispredict = 0, branch_count = 1, mispredict_count = 0.
- Decode at PC 0x200 with prediction = 0, target 0x180, actual = 1 -> mispredict = 1 for one cycle, recover_pc = 0x180, mispredict_count = 1.
- Decode at PC 0xFFFF_FFFC with prediction = 1, actual = 0 -> recover_pc = 0x0000_0000 (wrap); a younger branch decoded one cycle later is squashed and never counted.
- branch_mem_sig pulsed with no prior decode -> orphan_err = 1 and stays 1; counters stay 0; reset clears orphan_err.
- Mispredicting resolution presented with stall = 1 for 3 cycles -> mispredict = 0 throughout the stall; after stall drops, mispredict = 1 for exactly one cycle and mispredict_count increments by 1.
- Counters with CNT_WIDTH = 4: after 17 resolved mispredicts -> branch_count = 15 and mispredict_count = 15 (saturated); assert reset mid-resolution -> all outputs return to 0 on the next edge.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Signal bundle between the pipeline control and the branch resolve unit.
// The master side drives decode/resolve inputs; the slave side returns recovery and counters.
interface branch_resolve_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 stall;
  logic                 branch_decode_sig;
  logic                 prediction;
  logic [31:0]          decode_pc;
  logic [31:0]          branch_addr;
  logic                 branch_mem_sig;
  logic                 actual_branch_decision;
  logic                 mispredict;
  logic [31:0]          recover_pc;
  logic [CNT_WIDTH-1:0] branch_count;
  logic [CNT_WIDTH-1:0] mispredict_count;
  logic                 orphan_err;

  modport master (
    output stall, branch_decode_sig, prediction, decode_pc, branch_addr,
           branch_mem_sig, actual_branch_decision,
    input  mispredict, recover_pc, branch_count, mispredict_count, orphan_err
  );

  modport slave (
    input  stall, branch_decode_sig, prediction, decode_pc, branch_addr,
           branch_mem_sig, actual_branch_decision,
    output mispredict, recover_pc, branch_count, mispredict_count, orphan_err
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Carries branch records decode -> ex -> mem, resolves them against the actual outcome,
// drives fetch recovery on a mispredict and keeps saturating performance counters.
module branch_resolve_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  branch_resolve_if.slave  bus
);

  typedef struct packed {
    logic        valid;
    logic        pred;
    logic [31:0] fallthrough;
    logic [31:0] target;
  } rec_t;

  rec_t                 ex_rec_q, ex_rec_d;
  rec_t                 mem_rec_q, mem_rec_d;
  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;
  logic                 orphan_err_q, orphan_err_d;

  logic                 resolve_active;
  logic                 mispredict;
  logic [31:0]          recover_pc;

  always_comb begin
    resolve_active = bus.branch_mem_sig & mem_rec_q.valid & ~bus.stall;
    mispredict     = resolve_active & (mem_rec_q.pred ^ bus.actual_branch_decision);
    recover_pc     = 32'h0;
    if (mispredict) begin
      recover_pc = bus.actual_branch_decision ? mem_rec_q.target : mem_rec_q.fallthrough;
    end
  end

  always_comb begin
    ex_rec_d           = ex_rec_q;
    mem_rec_d          = mem_rec_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    orphan_err_d       = orphan_err_q;

    if (!bus.stall) begin
      // A mispredict flushes both the resolving record and the younger one,
      // and wins over a branch arriving in decode the same cycle.
      if (mispredict) begin
        ex_rec_d  = '0;
        mem_rec_d = '0;
      end else begin
        mem_rec_d = ex_rec_q;
        ex_rec_d  = '{valid:       bus.branch_decode_sig,
                      pred:        bus.prediction,
                      fallthrough: bus.decode_pc + 32'd4,
                      target:      bus.branch_addr};
      end

      if (resolve_active && branch_count_q != '1) begin
        branch_count_d = branch_count_q + CNT_WIDTH'(1);
      end
      if (mispredict && mispredict_count_q != '1) begin
        mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
      end
      if (bus.branch_mem_sig && !mem_rec_q.valid) begin
        orphan_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rec_q           <= '0;
      mem_rec_q          <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      orphan_err_q       <= 1'b0;
    end else begin
      ex_rec_q           <= ex_rec_d;
      mem_rec_q          <= mem_rec_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      orphan_err_q       <= orphan_err_d;
    end
  end

  assign bus.mispredict       = mispredict;
  assign bus.recover_pc       = recover_pc;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;
  assign bus.orphan_err       = orphan_err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a 32-bit counter instance for the main
// scenarios and a 4-bit counter instance for saturation and mid-resolution reset.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic rst;
  logic rst4;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_resolve_if #(.CNT_WIDTH(32)) bus ();
  branch_resolve_if #(.CNT_WIDTH(4))  bus4 ();

  branch_resolve_unit #(.CNT_WIDTH(32)) dut (.clk(clk), .reset(rst), .bus(bus));
  branch_resolve_unit #(.CNT_WIDTH(4))  dut4 (.clk(clk), .reset(rst4), .bus(bus4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall = 0; bus.branch_decode_sig = 0; bus.prediction = 0;
    bus.decode_pc = '0; bus.branch_addr = '0;
    bus.branch_mem_sig = 0; bus.actual_branch_decision = 0;
    bus4.stall = 0; bus4.branch_decode_sig = 0; bus4.prediction = 0;
    bus4.decode_pc = '0; bus4.branch_addr = '0;
    bus4.branch_mem_sig = 0; bus4.actual_branch_decision = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1; rst4 = 1;
    step(); step();
    rst = 0; rst4 = 0;
  endtask

  // Presents one decode branch for a single cycle; on return it sits in ex_rec.
  task automatic decode_one(input logic [31:0] pc, input logic [31:0] addr, input logic pred);
    bus.branch_decode_sig = 1; bus.decode_pc = pc; bus.branch_addr = addr; bus.prediction = pred;
    step();
    bus.branch_decode_sig = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.stall = 1;
    rst = 1; rst4 = 1;
    step(); step();
    #1;
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL rst_mispredict got %0b exp 0", bus.mispredict); end
    checks++; if (bus.recover_pc !== 32'h0) begin errors++; $display("FAIL rst_recover_pc got %h exp 0", bus.recover_pc); end
    checks++; if (bus.branch_count !== 32'd0) begin errors++; $display("FAIL rst_branch_count got %0d exp 0", bus.branch_count); end
    checks++; if (bus.mispredict_count !== 32'd0) begin errors++; $display("FAIL rst_mispredict_count got %0d exp 0", bus.mispredict_count); end
    checks++; if (bus.orphan_err !== 1'b0) begin errors++; $display("FAIL rst_orphan got %0b exp 0", bus.orphan_err); end
    rst = 0; rst4 = 0; bus.stall = 0;
  endtask

  task automatic test_correct_taken();
    do_reset();
    decode_one(32'h100, 32'h140, 1'b1);
    step();
    bus.branch_mem_sig = 1; bus.actual_branch_decision = 1;
    #1;
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL t1_mispredict got %0b exp 0", bus.mispredict); end
    checks++; if (bus.recover_pc !== 32'h0) begin errors++; $display("FAIL t1_recover_pc got %h exp 0", bus.recover_pc); end
    step();
    bus.branch_mem_sig = 0;
    checks++; if (bus.branch_count !== 32'd1) begin errors++; $display("FAIL t1_branch_count got %0d exp 1", bus.branch_count); end
    checks++; if (bus.mispredict_count !== 32'd0) begin errors++; $display("FAIL t1_mispredict_count got %0d exp 0", bus.mispredict_count); end
  endtask

  task automatic test_mispredict_taken();
    do_reset();
    decode_one(32'h200, 32'h180, 1'b0);
    step();
    bus.branch_mem_sig = 1; bus.actual_branch_decision = 1;
    #1;
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL t2_mispredict got %0b exp 1", bus.mispredict); end
    checks++; if (bus.recover_pc !== 32'h180) begin errors++; $display("FAIL t2_recover_pc got %h exp 00000180", bus.recover_pc); end
    step();
    bus.branch_mem_sig = 0;
    #1;
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL t2_mispredict_after got %0b exp 0", bus.mispredict); end
    checks++; if (bus.mispredict_count !== 32'd1) begin errors++; $display("FAIL t2_mispredict_count got %0d exp 1", bus.mispredict_count); end
    checks++; if (bus.branch_count !== 32'd1) begin errors++; $display("FAIL t2_branch_count got %0d exp 1", bus.branch_count); end
  endtask

  task automatic test_wrap_squash();
    do_reset();
    decode_one(32'hFFFF_FFFC, 32'h40, 1'b1);
    // Younger branch enters decode while the older one moves to mem.
    decode_one(32'h0000_0000, 32'h80, 1'b0);
    bus.branch_mem_sig = 1; bus.actual_branch_decision = 0;
    #1;
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL t3_mispredict got %0b exp 1", bus.mispredict); end
    checks++; if (bus.recover_pc !== 32'h0) begin errors++; $display("FAIL t3_recover_pc_wrap got %h exp 00000000", bus.recover_pc); end
    step();
    // Where the younger branch would resolve: it must have been squashed.
    bus.branch_mem_sig = 1; bus.actual_branch_decision = 1;
    #1;
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL t3_squashed_mispredict got %0b exp 0", bus.mispredict); end
    step();
    bus.branch_mem_sig = 0;
    checks++; if (bus.branch_count !== 32'd1) begin errors++; $display("FAIL t3_branch_count got %0d exp 1", bus.branch_count); end
    checks++; if (bus.mispredict_count !== 32'd1) begin errors++; $display("FAIL t3_mispredict_count got %0d exp 1", bus.mispredict_count); end
    checks++; if (bus.orphan_err !== 1'b1) begin errors++; $display("FAIL t3_orphan got %0b exp 1", bus.orphan_err); end
  endtask

  task automatic test_orphan();
    do_reset();
    bus.branch_mem_sig = 1; bus.actual_branch_decision = 1;
    #1;
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL t4_mispredict got %0b exp 0", bus.mispredict); end
    step();
    bus.branch_mem_sig = 0;
    checks++; if (bus.orphan_err !== 1'b1) begin errors++; $display("FAIL t4_orphan_set got %0b exp 1", bus.orphan_err); end
    step(); step(); step();
    checks++; if (bus.orphan_err !== 1'b1) begin errors++; $display("FAIL t4_orphan_sticky got %0b exp 1", bus.orphan_err); end
    checks++; if (bus.branch_count !== 32'd0) begin errors++; $display("FAIL t4_branch_count got %0d exp 0", bus.branch_count); end
    checks++; if (bus.mispredict_count !== 32'd0) begin errors++; $display("FAIL t4_mispredict_count got %0d exp 0", bus.mispredict_count); end
    rst = 1;
    step();
    rst = 0;
    checks++; if (bus.orphan_err !== 1'b0) begin errors++; $display("FAIL t4_orphan_reset got %0b exp 0", bus.orphan_err); end
  endtask

  task automatic test_stall();
    do_reset();
    decode_one(32'h300, 32'h340, 1'b1);
    step();
    bus.stall = 1; bus.branch_mem_sig = 1; bus.actual_branch_decision = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL t5_stall_mispredict[%0d] got %0b exp 0", i, bus.mispredict); end
      step();
      checks++; if (bus.branch_count !== 32'd0) begin errors++; $display("FAIL t5_stall_count[%0d] got %0d exp 0", i, bus.branch_count); end
    end
    bus.stall = 0;
    #1;
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL t5_release_mispredict got %0b exp 1", bus.mispredict); end
    checks++; if (bus.recover_pc !== 32'h304) begin errors++; $display("FAIL t5_recover_pc got %h exp 00000304", bus.recover_pc); end
    step();
    bus.branch_mem_sig = 0;
    #1;
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL t5_one_cycle got %0b exp 0", bus.mispredict); end
    checks++; if (bus.mispredict_count !== 32'd1) begin errors++; $display("FAIL t5_mispredict_count got %0d exp 1", bus.mispredict_count); end
    checks++; if (bus.branch_count !== 32'd1) begin errors++; $display("FAIL t5_branch_count got %0d exp 1", bus.branch_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    decode_one(32'h400, 32'h480, 1'b1);
    decode_one(32'h404, 32'h500, 1'b1);
    bus.branch_mem_sig = 1; bus.actual_branch_decision = 1;
    #1;
    checks++; if (bus.mispredict !== 1'b0) begin errors++; $display("FAIL t6_first_mispredict got %0b exp 0", bus.mispredict); end
    step();
    bus.actual_branch_decision = 0;
    #1;
    checks++; if (bus.mispredict !== 1'b1) begin errors++; $display("FAIL t6_second_mispredict got %0b exp 1", bus.mispredict); end
    checks++; if (bus.recover_pc !== 32'h408) begin errors++; $display("FAIL t6_recover_pc got %h exp 00000408", bus.recover_pc); end
    step();
    bus.branch_mem_sig = 0;
    checks++; if (bus.branch_count !== 32'd2) begin errors++; $display("FAIL t6_branch_count got %0d exp 2", bus.branch_count); end
    checks++; if (bus.mispredict_count !== 32'd1) begin errors++; $display("FAIL t6_mispredict_count got %0d exp 1", bus.mispredict_count); end
    checks++; if (bus.orphan_err !== 1'b0) begin errors++; $display("FAIL t6_orphan got %0b exp 0", bus.orphan_err); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 0; n < 17; n++) begin
      bus4.branch_decode_sig = 1; bus4.decode_pc = 32'h1000 + 32'(n * 16);
      bus4.branch_addr = 32'h2000; bus4.prediction = 0;
      step();
      bus4.branch_decode_sig = 0;
      step();
      bus4.branch_mem_sig = 1; bus4.actual_branch_decision = 1;
      step();
      bus4.branch_mem_sig = 0;
    end
    checks++; if (bus4.branch_count !== 4'd15) begin errors++; $display("FAIL t7_branch_count_sat got %0d exp 15", bus4.branch_count); end
    checks++; if (bus4.mispredict_count !== 4'd15) begin errors++; $display("FAIL t7_mispredict_count_sat got %0d exp 15", bus4.mispredict_count); end
    // Reset lands on the edge of a mispredicting resolution.
    bus4.branch_decode_sig = 1; bus4.decode_pc = 32'h3000; bus4.branch_addr = 32'h3100; bus4.prediction = 0;
    step();
    bus4.branch_decode_sig = 0;
    step();
    bus4.branch_mem_sig = 1; bus4.actual_branch_decision = 1;
    #1;
    checks++; if (bus4.mispredict !== 1'b1) begin errors++; $display("FAIL t7_pre_reset_mispredict got %0b exp 1", bus4.mispredict); end
    rst4 = 1;
    step();
    checks++; if (bus4.mispredict !== 1'b0) begin errors++; $display("FAIL t7_reset_mispredict got %0b exp 0", bus4.mispredict); end
    checks++; if (bus4.recover_pc !== 32'h0) begin errors++; $display("FAIL t7_reset_recover_pc got %h exp 0", bus4.recover_pc); end
    checks++; if (bus4.branch_count !== 4'd0) begin errors++; $display("FAIL t7_reset_branch_count got %0d exp 0", bus4.branch_count); end
    checks++; if (bus4.mispredict_count !== 4'd0) begin errors++; $display("FAIL t7_reset_mispredict_count got %0d exp 0", bus4.mispredict_count); end
    checks++; if (bus4.orphan_err !== 1'b0) begin errors++; $display("FAIL t7_reset_orphan got %0b exp 0", bus4.orphan_err); end
    bus4.branch_mem_sig = 0;
    rst4 = 0;
  endtask

  initial begin
    rst = 1; rst4 = 1;
    clear_inputs();
    test_reset();
    test_correct_taken();
    test_mispredict_taken();
    test_wrap_squash();
    test_orphan();
    test_stall();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
